// File: rtl/trig_frame_pkg.sv
// trig_frame_pkg: shared constants and types for the trigger frame generator.
//   - K-codes and the trigger control code placed on the link
//   - byte-index offsets of the fixed header fields within a frame
//   - FSM state type used by trig_frame_gen
//   - frame_len(): frame length in bytes for a given payload length
package trig_frame_pkg;

   localparam logic [7:0] SOP_CODE  = 8'h3C;
   localparam logic [7:0] EOP_CODE  = 8'hBC;
   localparam logic [7:0] TRIG_CODE = 8'h08;

   localparam int IDX_SOP     = 0;
   localparam int IDX_STATUS  = 1;
   localparam int IDX_CTRL    = 2;
   localparam int IDX_MASK    = 3;
   localparam int IDX_PAYLOAD = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRIG  = 2'd2
   } trig_state_e;

   // Header (SOP, status, control, mask) + payload + CRC + EOP.
   function automatic int frame_len(input int payload_bytes);
      return payload_bytes + 6;
   endfunction

endpackage

// File: rtl/trig_frame_gen_if.sv
// trig_frame_gen_if: trigger-request inputs and byte-stream outputs of the
// trigger frame generator.
//   trigger_pulse   : per-channel trigger request (into the generator)
//   data            : current frame byte
//   is_control_byte : SOP/EOP K-code marker
//   is_crc_byte     : CRC byte slot marker
//   crc_reset       : CRC restart on SOP
//   frame_start     : byte index 0 marker
//   trigger_ack     : per-channel acknowledge on the control-byte cycle
// Modports: master = the generator, slave = trigger source / link consumer.
interface trig_frame_gen_if #(
   parameter int NUM_CH = 4
) ();

   logic [NUM_CH-1:0] trigger_pulse;
   logic [7:0]        data;
   logic              is_control_byte;
   logic              is_crc_byte;
   logic              crc_reset;
   logic              frame_start;
   logic [NUM_CH-1:0] trigger_ack;

   modport master (
      input  trigger_pulse,
      output data,
      output is_control_byte,
      output is_crc_byte,
      output crc_reset,
      output frame_start,
      output trigger_ack
   );

   modport slave (
      output trigger_pulse,
      input  data,
      input  is_control_byte,
      input  is_crc_byte,
      input  crc_reset,
      input  frame_start,
      input  trigger_ack
   );

endinterface

// File: rtl/trig_frame_gen_capture.sv
// trig_req_capture: per-channel trigger request latch.
//   clk, reset     : byte clock, asynchronous active-high reset
//   trigger_pulse  : per-channel requests, sampled every clock
//   wrap           : high in the last byte cycle of a frame (snapshot edge next)
//   frame_mask     : channels reported in the current frame
//   frame_ovr      : a channel requested more than once in the previous interval
//   snap_any       : the snapshot taken at the coming wrap edge is nonzero
module trig_req_capture
   import trig_frame_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] trigger_pulse,
   input  logic              wrap,
   output logic [NUM_CH-1:0] frame_mask,
   output logic              frame_ovr,
   output logic              snap_any
);

   logic [NUM_CH-1:0] pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic [NUM_CH-1:0] frame_mask_q, frame_mask_d;
   logic              frame_ovr_q, frame_ovr_d;

   always_comb begin
      pending_d    = pending_q;
      overrun_d    = overrun_q;
      frame_mask_d = frame_mask_q;
      frame_ovr_d  = frame_ovr_q;
      if (wrap) begin
         // Pulses on the snapshot edge go straight into the new frame and are
         // not re-latched, so pending starts the next interval empty.
         frame_mask_d = pending_q | trigger_pulse;
         frame_ovr_d  = overrun_q;
         pending_d    = '0;
         overrun_d    = 1'b0;
      end else begin
         pending_d = pending_q | trigger_pulse;
         overrun_d = overrun_q | (|(pending_q & trigger_pulse));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q    <= '0;
         overrun_q    <= 1'b0;
         frame_mask_q <= '0;
         frame_ovr_q  <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         frame_mask_q <= frame_mask_d;
         frame_ovr_q  <= frame_ovr_d;
      end
   end

   assign frame_mask = frame_mask_q;
   assign frame_ovr  = frame_ovr_q;
   assign snap_any   = |(pending_q | trigger_pulse);

endmodule

// File: rtl/trig_frame_gen.sv
// trig_frame_gen: continuous back-to-back trigger frame generator, one byte
// per clock, feeding the 8b/10b encoder and CRC8 generator.
//   clk, reset : byte clock, asynchronous active-high reset
//   link       : trig_frame_gen_if.master (trigger_pulse in; data,
//                is_control_byte, is_crc_byte, crc_reset, frame_start,
//                trigger_ack out)
// Frame: SOP, status {ovr, seq}, control, mask, PAYLOAD_BYTES x 00, CRC, EOP.
// Build option: define TRIG_FRAME_SEQ_EN to carry a 7-bit frame sequence
// number in status[6:0]; otherwise status[6:0] is zero.
// All outputs decode from registers only.
module trig_frame_gen
   import trig_frame_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int PAYLOAD_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   trig_frame_gen_if.master  link
);

   localparam int FRAME_LEN = frame_len(PAYLOAD_BYTES);
   localparam int IDX_W     = $clog2(FRAME_LEN);

   localparam logic [IDX_W-1:0] SOP_IDX    = IDX_W'(IDX_SOP);
   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(IDX_STATUS);
   localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(IDX_CTRL);
   localparam logic [IDX_W-1:0] MASK_IDX   = IDX_W'(IDX_MASK);
   localparam logic [IDX_W-1:0] CRC_IDX    = IDX_W'(IDX_PAYLOAD + PAYLOAD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);

   logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
   trig_state_e       state_q, state_d;
   logic              wrap;
   logic [NUM_CH-1:0] frame_mask;
   logic              frame_ovr;
   logic              snap_any;
   logic [7:0]        status_byte;

   assign wrap = (byte_idx_q == LAST_IDX);

   trig_req_capture #(
      .NUM_CH (NUM_CH)
   ) u_capture (
      .clk           (clk),
      .reset         (reset),
      .trigger_pulse (link.trigger_pulse),
      .wrap          (wrap),
      .frame_mask    (frame_mask),
      .frame_ovr     (frame_ovr),
      .snap_any      (snap_any)
   );

   // Byte counter
   always_comb begin
      byte_idx_d = wrap ? '0 : byte_idx_q + 1'b1;
   end

   // FSM: TRIG tracks a nonzero snapshot; ARMED is only reachable from IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (wrap) begin
               state_d = snap_any ? S_TRIG : S_IDLE;
            end else if (|link.trigger_pulse) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (wrap) begin
               state_d = snap_any ? S_TRIG : S_IDLE;
            end
         end
         S_TRIG: begin
            if (wrap && !snap_any) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx_q <= '0;
         state_q    <= S_IDLE;
      end else begin
         byte_idx_q <= byte_idx_d;
         state_q    <= state_d;
      end
   end

`ifdef TRIG_FRAME_SEQ_EN
   logic [6:0] seq_q, seq_d;

   // Advances on the same edge as the snapshot, so frame k carries k mod 128.
   always_comb begin
      seq_d = wrap ? seq_q + 7'd1 : seq_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end

   assign status_byte = {frame_ovr, seq_q};
`else
   assign status_byte = {frame_ovr, 7'b0};
`endif

   // Output decode
   logic [7:0]        data_c;
   logic              ctrl_c;
   logic              crc_c;
   logic              sop_c;
   logic [NUM_CH-1:0] ack_c;

   always_comb begin
      data_c = '0;
      ctrl_c = 1'b0;
      crc_c  = 1'b0;
      sop_c  = 1'b0;
      ack_c  = '0;
      if (byte_idx_q == SOP_IDX) begin
         data_c = SOP_CODE;
         ctrl_c = 1'b1;
         sop_c  = 1'b1;
      end else if (byte_idx_q == STATUS_IDX) begin
         data_c = status_byte;
      end else if (byte_idx_q == CTRL_IDX) begin
         if (state_q == S_TRIG) begin
            data_c = TRIG_CODE;
            ack_c  = frame_mask;
         end
      end else if (byte_idx_q == MASK_IDX) begin
         data_c = 8'(frame_mask);
      end else if (byte_idx_q == CRC_IDX) begin
         crc_c = 1'b1;
      end else if (byte_idx_q == LAST_IDX) begin
         data_c = EOP_CODE;
         ctrl_c = 1'b1;
      end
   end

   assign link.data            = data_c;
   assign link.is_control_byte = ctrl_c;
   assign link.is_crc_byte     = crc_c;
   assign link.crc_reset       = sop_c;
   assign link.frame_start     = sop_c;
   assign link.trigger_ack     = ack_c;

endmodule

// File: tb/tb_trig_frame_gen.sv
module tb_trig_frame_gen;

   localparam int FL = 10;

   typedef struct packed {
      logic [7:0] data;
      logic       ctrl;
      logic       crc;
      logic       crst;
      logic       fs;
      logic [3:0] ack;
   } obs_t;

   localparam obs_t RESET_OBS = '{data: 8'h3C, ctrl: 1'b1, crc: 1'b0, crst: 1'b1, fs: 1'b1, ack: 4'h0};

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic [3:0] hist [0:4095];
   obs_t obs, expv;

   always #5 clk = ~clk;

   trig_frame_gen_if #(.NUM_CH(4)) tif ();

   trig_frame_gen #(.NUM_CH(4), .PAYLOAD_BYTES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .link  (tif)
   );

   function automatic obs_t sample();
      obs_t o;
      o.data = tif.data;
      o.ctrl = tif.is_control_byte;
      o.crc  = tif.is_crc_byte;
      o.crst = tif.crc_reset;
      o.fs   = tif.frame_start;
      o.ack  = tif.trigger_ack;
      return o;
   endfunction

   // Reference: frame f reports everything requested during frame f-1's
   // cycles; overrun if some channel requested in two cycles of that frame,
   // not counting a repeat that lands on its last cycle.
   function automatic obs_t model_out(input int c);
      obs_t o;
      int f = c / FL;
      int i = c % FL;
      logic [3:0] m = '0;
      logic ovr = 1'b0;
      logic [7:0] st;
      if (f > 0) begin
         for (int k = FL*(f-1); k < FL*f; k++) m |= hist[k];
         for (int ch = 0; ch < 4; ch++) begin
            int n = 0;
            for (int k = FL*(f-1); k < FL*f - 1; k++) if (hist[k][ch]) n++;
            if (n >= 2) ovr = 1'b1;
         end
      end
`ifdef TRIG_FRAME_SEQ_EN
      st = {ovr, 7'(f % 128)};
`else
      st = {ovr, 7'd0};
`endif
      o = '{data: 8'h00, ctrl: 1'b0, crc: 1'b0, crst: 1'b0, fs: 1'b0, ack: 4'h0};
      case (i)
         0: begin o.data = 8'h3C; o.ctrl = 1'b1; o.crst = 1'b1; o.fs = 1'b1; end
         1: o.data = st;
         2: begin o.data = (m != 0) ? 8'h08 : 8'h00; o.ack = m; end
         3: o.data = {4'h0, m};
         8: o.crc = 1'b1;
         9: begin o.data = 8'hBC; o.ctrl = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic clear_hist();
      for (int k = 0; k < 4096; k++) hist[k] = '0;
      cyc = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tif.trigger_pulse = 4'hF;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tif.trigger_pulse = 4'h0;
      clear_hist();
   endtask

   task automatic drive(input logic [3:0] p);
      tif.trigger_pulse = p;
      hist[cyc] = p;
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tif.trigger_pulse = 4'hF;
      repeat (3) begin
         @(negedge clk);
         obs = sample();
         total++;
         if (obs !== RESET_OBS) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", obs, RESET_OBS);
         end
      end
      do_reset();
   endtask

   task automatic test_idle_frames();
      do_reset();
      for (int c = 0; c < 5*FL; c++) begin
         drive(4'h0);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL idle cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_single_trigger();
      do_reset();
      for (int c = 0; c < 3*FL; c++) begin
         drive((c == 4) ? 4'b0010 : 4'b0000);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         if (c == 12) begin
            total++;
            if (tif.data !== 8'h08 || tif.trigger_ack !== 4'b0010) begin
               bad++;
               $display("FAIL single_ctrl data=%h ack=%b want 08/0010", tif.data, tif.trigger_ack);
            end
         end
         if (c == 22) begin
            total++;
            if (tif.data !== 8'h00 || tif.trigger_ack !== 4'b0000) begin
               bad++;
               $display("FAIL single_after data=%h ack=%b want 00/0000", tif.data, tif.trigger_ack);
            end
         end
         advance();
      end
   endtask

   task automatic test_wrap_edge();
      do_reset();
      for (int c = 0; c < 3*FL + 5; c++) begin
         drive((c == 9) ? 4'b0001 : (c == 10) ? 4'b1000 : 4'b0000);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL wrap_edge cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         if (c == 13 || c == 23) begin
            total++;
            if (tif.data !== ((c == 13) ? 8'h01 : 8'h08)) begin
               bad++;
               $display("FAIL wrap_mask cyc=%0d got=%h want=%h", c, tif.data, (c == 13) ? 8'h01 : 8'h08);
            end
         end
         advance();
      end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int c = 0; c < 3*FL; c++) begin
         drive((c == 3 || c == 6) ? 4'b0010 : 4'b0000);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL overrun cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         if (c == 11 || c == 21) begin
            total++;
            if (tif.data[7] !== (c == 11)) begin
               bad++;
               $display("FAIL overrun_bit cyc=%0d got=%b want=%b", c, tif.data[7], (c == 11));
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      for (int c = 0; c <= 16; c++) begin
         drive((c == 14) ? 4'b0100 : 4'b0000);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL midreset_pre cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         if (c < 16) advance();
      end
      #2;
      reset = 1'b1;
      tif.trigger_pulse = 4'hF;
      #1;
      obs = sample();
      total++;
      if (obs !== RESET_OBS) begin
         bad++;
         $display("FAIL midreset_async got=%h want=%h", obs, RESET_OBS);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tif.trigger_pulse = 4'h0;
      clear_hist();
      for (int c = 0; c < 2*FL + 5; c++) begin
         drive(4'h0);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL midreset_post cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic [3:0] p;
      do_reset();
      for (int c = 0; c < 135*FL; c++) begin
         p = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
         drive(p);
         obs = sample();
         expv = model_out(cyc);
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expv);
         end
         advance();
      end
   endtask

   initial begin
      tif.trigger_pulse = 4'h0;
      test_reset();
      test_idle_frames();
      test_single_trigger();
      test_wrap_edge();
      test_overrun();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
